// File: rtl/video_timing_rx_if.sv
// rtl/video_timing_rx_if.sv - incoming RGB video bundle (sync, enable, pixel)
interface video_timing_rx_if;
    logic        video_hs;
    logic        video_vs;
    logic        video_de;
    logic [23:0] video_rgb;

    modport master (output video_hs, video_vs, video_de, video_rgb);
    modport slave  (input  video_hs, video_vs, video_de, video_rgb);
endinterface

// File: rtl/video_timing_rx.sv
// rtl/video_timing_rx.sv - video timing receiver: pixel coordinates, geometry measurement, format lock
module video_timing_rx #(
    parameter int EXP_H_DISP  = 1280,
    parameter int EXP_V_DISP  = 720,
    parameter int EXP_H_TOTAL = 1650,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                    pixel_clk,
    input  logic                    sys_rst_n,
    video_timing_rx_if.slave        vin,
    output logic                    pix_valid,
    output logic [23:0]             pix_data,
    output logic [10:0]             pix_x,
    output logic [10:0]             pix_y,
    output logic                    frame_start,
    output logic [10:0]             meas_h_active,
    output logic [10:0]             meas_v_active,
    output logic [10:0]             meas_h_total,
    output logic                    locked,
    output logic                    fmt_err
);
    localparam logic [10:0] CNT_MAX   = 11'h7ff;
    localparam logic [10:0] EXP_H     = 11'(EXP_H_DISP);
    localparam logic [10:0] EXP_V     = 11'(EXP_V_DISP);
    localparam logic [10:0] EXP_HT    = 11'(EXP_H_TOTAL);
    localparam logic [2:0]  LOCK_GOOD = 3'(LOCK_FRAMES);

    typedef enum logic [1:0] {WAIT_VS, MEASURE, LOCKED} state_t;

    logic        s1_hs, s1_vs, s1_de, s2_hs, s2_vs, s2_de;
    logic [23:0] s1_rgb, s2_rgb;
    logic        hs_fall, vs_fall, de_rise, de_fall;
    logic [10:0] x_pos, y_pos;
    logic        hs_fall_q, vs_fall_q, de_fall_q, de_vs_q, x_sat_q;
    logic [10:0] h_cnt, line_cnt;
    logic        hs_seen, bad_mark;
    state_t      state, state_nxt;
    logic [2:0]  good_cnt, good_cnt_nxt;
    logic        fmt_err_nxt;
    logic [10:0] h_len, h_period, v_lines;
    logic        bad_evt, frame_good;

    assign hs_fall = s2_hs & ~s1_hs;
    assign vs_fall = s2_vs & ~s1_vs;
    assign de_rise = s1_de & ~s2_de;
    assign de_fall = s2_de & ~s1_de;

    // x_pos/y_pos describe the pixel held in stage 2, so they advance from stage-1 edges
    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1_hs <= 1'b0; s1_vs <= 1'b0; s1_de <= 1'b0; s1_rgb <= '0;
            s2_hs <= 1'b0; s2_vs <= 1'b0; s2_de <= 1'b0; s2_rgb <= '0;
            x_pos <= '0; y_pos <= '0;
            hs_fall_q <= 1'b0; vs_fall_q <= 1'b0; de_fall_q <= 1'b0;
            de_vs_q <= 1'b0; x_sat_q <= 1'b0;
        end else begin
            s1_hs <= vin.video_hs; s1_vs <= vin.video_vs;
            s1_de <= vin.video_de; s1_rgb <= vin.video_rgb;
            s2_hs <= s1_hs; s2_vs <= s1_vs; s2_de <= s1_de; s2_rgb <= s1_rgb;
            if (s1_de) begin
                if (de_rise)               x_pos <= '0;
                else if (x_pos != CNT_MAX) x_pos <= x_pos + 11'd1;
            end
            if (vs_fall)                          y_pos <= '0;
            else if (de_fall && y_pos != CNT_MAX) y_pos <= y_pos + 11'd1;
            hs_fall_q <= hs_fall;
            vs_fall_q <= vs_fall;
            de_fall_q <= de_fall;
            de_vs_q   <= s1_de & ~s1_vs;
            x_sat_q   <= s1_de & ~de_rise & (x_pos == CNT_MAX - 11'd1);
        end
    end

    assign h_len    = (x_pos == CNT_MAX) ? CNT_MAX : x_pos + 11'd1;
    assign h_period = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 11'd1;
    // a line closing together with VS still belongs to the frame being judged
    assign v_lines  = (de_fall_q && line_cnt != CNT_MAX) ? line_cnt + 11'd1 : line_cnt;
    assign bad_evt  = (de_fall_q && h_len != EXP_H)
                    | (hs_fall_q && hs_seen && h_period != EXP_HT)
                    | de_vs_q | x_sat_q;
    assign frame_good = (v_lines == EXP_V) && !bad_mark && !bad_evt;

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pix_valid <= 1'b0; pix_data <= '0; pix_x <= '0; pix_y <= '0;
            frame_start <= 1'b0;
            meas_h_active <= '0; meas_v_active <= '0; meas_h_total <= '0;
            h_cnt <= '0; line_cnt <= '0; hs_seen <= 1'b0; bad_mark <= 1'b0;
            state <= WAIT_VS; good_cnt <= '0; fmt_err <= 1'b0;
        end else begin
            pix_valid   <= s2_de;
            pix_data    <= s2_rgb;
            pix_x       <= x_pos;
            pix_y       <= y_pos;
            frame_start <= s2_de && x_pos == '0 && y_pos == '0;
            if (hs_fall_q) begin
                h_cnt   <= '0;
                hs_seen <= 1'b1;
                if (hs_seen) meas_h_total <= h_period;
            end else if (h_cnt != CNT_MAX) begin
                h_cnt <= h_cnt + 11'd1;
            end
            if (de_fall_q) meas_h_active <= h_len;
            if (vs_fall_q) begin
                meas_v_active <= v_lines;
                line_cnt      <= '0;
                bad_mark      <= 1'b0;
            end else begin
                if (de_fall_q && line_cnt != CNT_MAX) line_cnt <= line_cnt + 11'd1;
                if (bad_evt) bad_mark <= 1'b1;
            end
            state    <= state_nxt;
            good_cnt <= good_cnt_nxt;
            fmt_err  <= fmt_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        good_cnt_nxt = good_cnt;
        fmt_err_nxt  = 1'b0;
        case (state)
            WAIT_VS: begin
                if (vs_fall_q) begin
                    state_nxt    = MEASURE;
                    good_cnt_nxt = '0;
                end
            end
            MEASURE: begin
                if (vs_fall_q) begin
                    if (!frame_good) begin
                        good_cnt_nxt = '0;
                    end else if (good_cnt + 3'd1 >= LOCK_GOOD) begin
                        state_nxt    = LOCKED;
                        good_cnt_nxt = '0;
                    end else begin
                        good_cnt_nxt = good_cnt + 3'd1;
                    end
                end
            end
            LOCKED: begin
                if (bad_evt || (vs_fall_q && !frame_good)) begin
                    state_nxt    = MEASURE;
                    good_cnt_nxt = '0;
                    fmt_err_nxt  = 1'b1;
                end
            end
            default: state_nxt = WAIT_VS;
        endcase
    end

    assign locked = (state == LOCKED);
endmodule

// File: tb/tb_video_timing_rx.sv
// tb/tb_video_timing_rx.sv - directed bench for video_timing_rx on a reduced 8x4 (16x7 total) format
module tb_video_timing_rx;
    localparam int H_D = 8, V_D = 4, H_T = 16, N_LINES = 7, DE_START = 4, VS_LINE = 5;

    logic        pixel_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        pix_valid, frame_start, locked, fmt_err;
    logic [23:0] pix_data;
    logic [10:0] pix_x, pix_y, meas_h_active, meas_v_active, meas_h_total;

    video_timing_rx_if vif();

    video_timing_rx #(
        .EXP_H_DISP(H_D), .EXP_V_DISP(V_D), .EXP_H_TOTAL(H_T), .LOCK_FRAMES(2)
    ) dut (
        .pixel_clk(pixel_clk), .sys_rst_n(sys_rst_n), .vin(vif),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .meas_h_active(meas_h_active),
        .meas_v_active(meas_v_active), .meas_h_total(meas_h_total),
        .locked(locked), .fmt_err(fmt_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    int errors = 0, checks = 0;
    int npv, nfs, nfe;
    bit chk_pix;
    logic lock_c2, lock_c3;
    logic [10:0] mh_bad;
    // what was driven 1..3 iterations ago; index 2 is what the outputs show now
    logic        ev [3];
    logic [10:0] ex [3];
    logic [10:0] ey [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic hs, input logic vs, input logic de,
                       input logic [10:0] x, input logic [10:0] y);
        @(negedge pixel_clk);
        if (pix_valid)   npv++;
        if (frame_start) nfs++;
        if (fmt_err)     nfe++;
        if (chk_pix) begin
            check("pix_valid", pix_valid, ev[2]);
            if (ev[2]) begin
                check("pix_x", pix_x, ex[2]);
                check("pix_y", pix_y, ey[2]);
                check("pix_data", pix_data, {2'b00, ex[2], ey[2]});
                check("frame_start", frame_start, (ex[2] == 0 && ey[2] == 0));
            end
        end
        ev[2] = ev[1]; ex[2] = ex[1]; ey[2] = ey[1];
        ev[1] = ev[0]; ex[1] = ex[0]; ey[1] = ey[0];
        ev[0] = de;    ex[0] = x;     ey[0] = y;
        vif.video_hs  = hs;
        vif.video_vs  = vs;
        vif.video_de  = de;
        vif.video_rgb = de ? {2'b00, x, y} : 24'h0;
    endtask

    task automatic frame(input int n_act, input int bad_line, input int bad_len, input int rst_col);
        npv = 0; nfs = 0; nfe = 0;
        for (int l = 0; l < N_LINES; l++) begin
            for (int c = 0; c < H_T; c++) begin
                int len = (l == bad_line) ? bad_len : H_D;
                logic de = (l < n_act) && (c >= DE_START) && (c < DE_START + len);
                cyc(c >= 2, l != VS_LINE, de, 11'(c - DE_START), 11'(l));
                if (l == VS_LINE && c == 2) lock_c2 = locked;
                if (l == VS_LINE && c == 3) lock_c3 = locked;
                if (l == bad_line && c == 15) mh_bad = meas_h_active;
                if (l == 1 && c == rst_col) begin
                    sys_rst_n = 1'b0;
                    #1;
                    check("rst_mid_locked", locked, 0);
                    check("rst_mid_pix_valid", pix_valid, 0);
                    check("rst_mid_pix_x", pix_x, 0);
                    check("rst_mid_pix_data", pix_data, 0);
                    check("rst_mid_meas_h_active", meas_h_active, 0);
                    check("rst_mid_meas_h_total", meas_h_total, 0);
                    check("rst_mid_meas_v_active", meas_v_active, 0);
                end
                if (l == 1 && c == rst_col + 3) sys_rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        vif.video_hs = 1'b1; vif.video_vs = 1'b1; vif.video_de = 1'b0; vif.video_rgb = '0;
        chk_pix = 1'b0;
        for (int i = 0; i < 3; i++) begin ev[i] = 1'b0; ex[i] = '0; ey[i] = '0; end
        repeat (3) @(negedge pixel_clk);
        check("reset_locked", locked, 0);
        check("reset_pix_valid", pix_valid, 0);
        check("reset_frame_start", frame_start, 0);
        check("reset_fmt_err", fmt_err, 0);
        check("reset_meas_h_active", meas_h_active, 0);
        check("reset_meas_v_active", meas_v_active, 0);
        check("reset_meas_h_total", meas_h_total, 0);
        sys_rst_n = 1'b1;

        frame(V_D, -1, 0, -1);
        check("f1_locked", locked, 0);
        frame(V_D, -1, 0, -1);
        check("f2_locked", locked, 0);
        check("f2_meas_h_active", meas_h_active, H_D);
        check("f2_meas_h_total", meas_h_total, H_T);
        check("f2_meas_v_active", meas_v_active, V_D);
        frame(V_D, -1, 0, -1);
        check("f3_lock_before", lock_c2, 0);
        check("f3_lock_after", lock_c3, 1);

        chk_pix = 1'b1;
        frame(V_D, -1, 0, -1);
        chk_pix = 1'b0;
        check("f4_pix_count", npv, H_D * V_D);
        check("f4_frame_start_count", nfs, 1);
        check("f4_fmt_err_count", nfe, 0);
        check("f4_locked", locked, 1);

        frame(V_D, 2, H_D - 1, -1);
        check("short_line_fmt_err", nfe, 1);
        check("short_line_locked", locked, 0);
        check("short_line_meas_h_active", mh_bad, H_D - 1);
        frame(V_D, -1, 0, -1);
        check("relock1_locked", locked, 0);
        frame(V_D, -1, 0, -1);
        check("relock2_locked", locked, 1);

        frame(V_D, 2, H_D - 1, -1);
        check("drop_again_locked", locked, 0);
        frame(V_D, -1, 0, -1);
        check("measure_cnt1_locked", locked, 0);
        frame(V_D - 1, -1, 0, -1);
        check("short_frame_fmt_err", nfe, 0);
        check("short_frame_locked", locked, 0);
        check("short_frame_meas_v_active", meas_v_active, V_D - 1);
        frame(V_D, -1, 0, -1);
        check("after_short_locked", locked, 0);
        frame(V_D, -1, 0, -1);
        check("after_short_relock", locked, 1);

        npv = 0; nfs = 0; nfe = 0;
        for (int i = 0; i < 3000; i++) cyc(1'b1, 1'b1, 1'b1, (i > 2047) ? 11'h7ff : 11'(i), 11'd0);
        check("sat_pix_x", pix_x, 2047);
        check("sat_fmt_err", nfe, 1);
        check("sat_locked", locked, 0);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 11'd0, 11'd0);
        check("sat_meas_h_active", meas_h_active, 2047);
        frame(V_D, -1, 0, -1);
        check("sat_frame_bad_locked", locked, 0);
        frame(V_D, -1, 0, -1);
        check("sat_cnt1_locked", locked, 0);
        frame(V_D, -1, 0, -1);
        check("sat_relock", locked, 1);

        frame(V_D, -1, 0, 9);
        check("rst_partial_locked", locked, 0);
        frame(V_D, -1, 0, -1);
        check("rst_good1_locked", locked, 0);
        frame(V_D, -1, 0, -1);
        check("rst_good2_locked", locked, 1);
        check("rst_meas_h_total", meas_h_total, H_T);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/video_timing_rx.md
# video_timing_rx

Receive-side counterpart of the HDMI/RGB video timing generator. Samples an incoming RGB888 stream with separate active-low HS/VS and active-high DE, and recovers per-pixel coordinates. Measures frame geometry and declares lock once the stream matches the expected format. Sits between the video input pins (or a loopback of the local driver) and downstream frame-buffer or overlay logic.

## Interface
Parameters:
- EXP_H_DISP, 1280: expected active pixels per line
- EXP_V_DISP, 720: expected active lines per frame
- EXP_H_TOTAL, 1650: expected pixel clocks per line (HS period)
- LOCK_FRAMES, 2: consecutive good frames required for lock (1..7)

Ports:
- pixel_clk  in  1  pixel clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- video_hs  in  1  horizontal sync, active low
- video_vs  in  1  vertical sync, active low
- video_de  in  1  data enable, active high
- video_rgb  in  24  RGB888 pixel
- pix_valid  out  1  pix_data/pix_x/pix_y valid
- pix_data  out  24  captured pixel
- pix_x  out  11  column, 0-based within the line
- pix_y  out  11  row, 0-based within the frame
- frame_start  out  1  one-cycle pulse with the pixel at (0,0)
- meas_h_active  out  11  DE-high length of the last line
- meas_v_active  out  11  DE lines in the last complete frame
- meas_h_total  out  11  HS falling-to-falling period of the last line
- locked  out  1  format lock
- fmt_err  out  1  one-cycle pulse on a mismatch while locked

## Operation
- Stage 1 registers hs, vs, de, rgb. Edges are detected against the stage-1 delayed copy: hs_fall, vs_fall, de_rise, de_fall.
- x counter: clears on de_rise and increments each DE-high cycle, saturating at 2047. y counter: clears on vs_fall and increments on de_fall, saturating at 2047.
- On de_fall: meas_h_active <= DE-high length. Any length differing from EXP_H_DISP marks the current frame bad.
- h period counter: clears on hs_fall, saturating at 2047. On hs_fall: meas_h_total <= count + 1. Any count + 1 differing from EXP_H_TOTAL marks the frame bad. The first hs_fall after reset only starts the counter and is neither loaded nor checked.
- On vs_fall: meas_v_active <= line count. The frame is good if the count equals EXP_V_DISP and no bad mark was set. The bad mark then clears.
- A frame is also bad if DE is high while VS is low, or if x saturates.
- Lock FSM, state changes on vs_fall only:
  - WAIT_VS (reset state): first vs_fall → MEASURE, good_cnt=0. The partial frame since reset is discarded.
  - MEASURE: good frame increments good_cnt. Reaching LOCK_FRAMES → LOCKED. Bad frame sets good_cnt=0 and stays in MEASURE.
  - LOCKED: good frame stays. Bad frame → MEASURE with good_cnt=0, and fmt_err pulses.
  - A bad mark raised mid-frame while LOCKED also drops lock immediately. fmt_err pulses once, and the FSM → MEASURE.
- locked = (state==LOCKED). Pixel outputs flow regardless of lock.
- Simultaneous vs_fall and de_fall: de_fall is counted into the closing frame first.

## Timing
- Reset, asynchronous: all outputs 0, FSM WAIT_VS, all counters 0.
- Pixel latency is 2 cycles. A video_de/video_rgb sample at edge N appears on pix_valid/pix_data at edge N+2, with pix_x/pix_y aligned to it.
- frame_start pulses together with pix_valid for the first pixel whose pix_y=0, pix_x=0.
- meas_* registers, locked and fmt_err update 2 cycles after the input edge that triggers them (the sampled hs/vs/de transition).
- Reset asserted mid-frame: outputs clear immediately. After release, lock needs 1 discarded partial frame plus LOCK_FRAMES good frames.

## Test plan
- Drive standard 1280x720 timing (1650x750 totals) from the local driver → meas_h_active=1280, meas_h_total=1650, meas_v_active=720. locked rises 2 cycles after the 3rd vs_fall after reset (LOCK_FRAMES=2).
- Locked stream, check pixels: rgb = {x,y} pattern → pix_x 0..1279 and pix_y 0..719 match the pattern, frame_start once per frame, pix_valid count 921600 per frame.
- Locked stream, one line with DE high for 1279 cycles → fmt_err single pulse, locked low, meas_h_active=1279. Relock after 2 further good frames.
- Frame with 719 DE lines while in MEASURE → good_cnt resets, no fmt_err, and locked stays low until 2 clean frames.
- DE held high 3000 cycles → pix_x saturates at 2047 and the frame is marked bad.
- Assert sys_rst_n low mid-line for 3 cycles → all outputs 0 at once. Lock reacquired only after partial + 2 good frames.
